// File: rtl/j1_io_pkg.sv
// Shared constants for the j1 I/O UART: default register addresses,
// status bit positions and the TX/RX state encodings.
package j1_io_pkg;
    localparam logic [15:0] ADDR_DATA_DEF = 16'h1000;
    localparam logic [15:0] ADDR_STAT_DEF = 16'h2000;

    localparam int ST_TX_READY = 0;
    localparam int ST_RX_VALID = 1;
    localparam int ST_RX_OVR   = 2;
    localparam int ST_TX_IDLE  = 3;
    localparam int ST_RX_FERR  = 4;
    localparam int ST_TX_OVF   = 5;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/j1_io_fifo.sv
// Synchronous FIFO with wrap-bit pointers; dout shows the head entry.
// Latency: a pushed word is visible on dout the cycle after the push edge.
// Backpressure: none internally; the caller only pushes when not full (or popping) and pops when not empty.
module j1_io_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = din;
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q[AW-1:0]];
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
endmodule

// File: rtl/j1_io_uart.sv
// j1 I/O-bus UART: data/status registers, TX FIFO + serialiser, RX deserialiser.
// Latency: io_din is combinational; a write reaches the line as a start bit 2 cycles after its edge.
// Backpressure: none; writes to a full FIFO are dropped and flagged in the sticky tx_ovf bit.
module j1_io_uart
    import j1_io_pkg::*;
#(
    parameter int          WIDTH     = 32,
    parameter int          CLKDIV    = 868,
    parameter int          TXDEPTH   = 4,
    parameter logic [15:0] ADDR_DATA = ADDR_DATA_DEF,
    parameter logic [15:0] ADDR_STAT = ADDR_STAT_DEF
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic             io_rd,
    input  logic             io_wr,
    input  logic [15:0]      io_addr,
    input  logic [WIDTH-1:0] io_dout,
    output logic [WIDTH-1:0] io_din,
    output logic             uart_tx,
    input  logic             uart_rx
);
    localparam int            BW        = $clog2(CLKDIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKDIV - 1);
    localparam logic [BW-1:0] BAUD_HALF = BW'(CLKDIV / 2 - 1);

    tx_state_t     tx_state_q, tx_state_d;
    rx_state_t     rx_state_q, rx_state_d;
    logic [BW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          uart_tx_q, uart_tx_d;
    logic          rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
    logic          rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d;
    logic          rx_ferr_q, rx_ferr_d, tx_ovf_q, tx_ovf_d;

    logic          rd_data, rd_stat, wr_data;
    logic          fifo_full, fifo_empty, tx_pop, tx_push, tx_tick, rx_tick;
    logic          rx_good, rx_bad;
    logic [7:0]    fifo_dout;
    logic          unused_dout;

    assign rd_data     = io_rd && (io_addr == ADDR_DATA);
    assign rd_stat     = io_rd && (io_addr == ADDR_STAT);
    assign wr_data     = io_wr && (io_addr == ADDR_DATA);
    // A pop in the same cycle frees a slot, so a write to a full FIFO still lands.
    assign tx_push     = wr_data && (!fifo_full || tx_pop);
    assign tx_tick     = (tx_cnt_q == BAUD_LAST);
    assign rx_tick     = (rx_cnt_q == BAUD_LAST);
    assign uart_tx     = uart_tx_q;
    assign unused_dout = ^io_dout[WIDTH-1:8];

    j1_io_fifo #(.WIDTH(8), .DEPTH(TXDEPTH)) u_txfifo (
        .clk    (clk),
        .resetq (resetq),
        .push   (tx_push),
        .pop    (tx_pop),
        .din    (io_dout[7:0]),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        if (tx_state_q != TX_IDLE) tx_cnt_d = tx_tick ? '0 : tx_cnt_q + BW'(1);
        case (tx_state_q)
            TX_IDLE: if (!fifo_empty) begin
                tx_pop     = 1'b1;
                tx_shift_d = fifo_dout;
                tx_cnt_d   = '0;
                tx_state_d = TX_START;
            end
            TX_START: if (tx_tick) begin
                tx_bit_d   = 3'd0;
                tx_state_d = TX_DATA;
            end
            TX_DATA: if (tx_tick) begin
                tx_shift_d = {1'b0, tx_shift_q[7:1]};
                tx_bit_d   = tx_bit_q + 3'd1;
                if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
            end
            TX_STOP: if (tx_tick) begin
                if (!fifo_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = fifo_dout;
                    tx_state_d = TX_START;
                end else begin
                    tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        // The line lags the state by one flop so uart_tx is glitch-free.
        case (tx_state_q)
            TX_START: uart_tx_d = 1'b0;
            TX_DATA:  uart_tx_d = tx_shift_q[0];
            default:  uart_tx_d = 1'b1;
        endcase
    end

    always_comb begin
        rx_s1_d    = uart_rx;
        rx_s2_d    = rx_s1_q;
        rx_prev_d  = rx_s2_q;
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_good    = 1'b0;
        rx_bad     = 1'b0;
        case (rx_state_q)
            RX_IDLE: if (rx_prev_q && !rx_s2_q) begin
                rx_cnt_d   = '0;
                rx_state_d = RX_START;
            end
            RX_START: begin
                rx_cnt_d = rx_cnt_q + BW'(1);
                if (rx_cnt_q == BAUD_HALF) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                rx_cnt_d = rx_tick ? '0 : rx_cnt_q + BW'(1);
                if (rx_tick) begin
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                rx_cnt_d = rx_tick ? '0 : rx_cnt_q + BW'(1);
                if (rx_tick) begin
                    rx_good    = rx_s2_q;
                    rx_bad     = !rx_s2_q;
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_valid_d = rx_valid_q;
        rx_byte_d  = rx_byte_q;
        rx_ovr_d   = rx_ovr_q;
        rx_ferr_d  = rx_ferr_q;
        tx_ovf_d   = tx_ovf_q;
        if (rd_stat) begin
            rx_ovr_d  = 1'b0;
            rx_ferr_d = 1'b0;
            tx_ovf_d  = 1'b0;
        end
        if (rd_data) rx_valid_d = 1'b0;
        // A frame completing while the old byte is being read is not an overrun.
        if (rx_good) begin
            if (!rx_valid_q || rd_data) begin
                rx_byte_d  = rx_shift_q;
                rx_valid_d = 1'b1;
            end else begin
                rx_ovr_d = 1'b1;
            end
        end
        if (rx_bad) rx_ferr_d = 1'b1;
        if (wr_data && !tx_push) tx_ovf_d = 1'b1;
    end

    always_comb begin
        io_din = '0;
        if (io_addr == ADDR_DATA) begin
            io_din[7:0] = rx_byte_q;
        end else if (io_addr == ADDR_STAT) begin
            io_din[ST_TX_READY] = !fifo_full;
            io_din[ST_RX_VALID] = rx_valid_q;
            io_din[ST_RX_OVR]   = rx_ovr_q;
            io_din[ST_TX_IDLE]  = fifo_empty && (tx_state_q == TX_IDLE);
            io_din[ST_RX_FERR]  = rx_ferr_q;
            io_din[ST_TX_OVF]   = tx_ovf_q;
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            tx_state_q <= TX_IDLE;
            rx_state_q <= RX_IDLE;
            tx_cnt_q   <= '0;
            rx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            rx_bit_q   <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_byte_q  <= '0;
            uart_tx_q  <= 1'b1;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
            rx_ferr_q  <= 1'b0;
            tx_ovf_q   <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            rx_state_q <= rx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_cnt_q   <= rx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            rx_bit_q   <= rx_bit_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_byte_q  <= rx_byte_d;
            uart_tx_q  <= uart_tx_d;
            rx_s1_q    <= rx_s1_d;
            rx_s2_q    <= rx_s2_d;
            rx_prev_q  <= rx_prev_d;
            rx_valid_q <= rx_valid_d;
            rx_ovr_q   <= rx_ovr_d;
            rx_ferr_q  <= rx_ferr_d;
            tx_ovf_q   <= tx_ovf_d;
        end
    end
endmodule

// File: tb/tb_j1_io_uart.sv
// Bench for j1_io_uart with CLKDIV=4, TXDEPTH=4: register reads and serial
// frames are checked by monitors against expectations queued by the stimulus.
module tb_j1_io_uart;
    localparam logic [15:0] A_DATA = 16'h1000;
    localparam logic [15:0] A_STAT = 16'h2000;

    logic        clk = 1'b0;
    logic        resetq;
    logic        io_rd, io_wr;
    logic [15:0] io_addr;
    logic [31:0] io_dout, io_din;
    logic        uart_tx, uart_rx;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] rd_exp[$];
    string       rd_name[$];
    logic [7:0]  tx_exp[$];
    int          tx_starts[$];
    logic        tx_busy = 1'b0;

    j1_io_uart #(.WIDTH(32), .CLKDIV(4), .TXDEPTH(4),
                 .ADDR_DATA(16'h1000), .ADDR_STAT(16'h2000)) dut (
        .clk     (clk),
        .resetq  (resetq),
        .io_rd   (io_rd),
        .io_wr   (io_wr),
        .io_addr (io_addr),
        .io_dout (io_dout),
        .io_din  (io_din),
        .uart_tx (uart_tx),
        .uart_rx (uart_rx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick();
    endtask

    task automatic rd(input logic [15:0] a, input logic [31:0] e, input string n);
        io_rd   = 1'b1;
        io_addr = a;
        rd_exp.push_back(e);
        rd_name.push_back(n);
        tick();
        io_rd   = 1'b0;
        io_addr = 16'h0;
    endtask

    task automatic wr(input logic [7:0] d, input logic exp_tx, output int at);
        io_wr   = 1'b1;
        io_addr = A_DATA;
        io_dout = {24'h0, d};
        if (exp_tx) tx_exp.push_back(d);
        tick();
        at      = cyc;
        io_wr   = 1'b0;
        io_addr = 16'h0;
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stopb);
        logic [9:0] f;
        f = {stopb, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = f[i];
            repeat (4) tick();
        end
        uart_rx = 1'b1;
        repeat (4) tick();
    endtask

    task automatic wait_tx_done(input int budget);
        int n;
        n = 0;
        while ((tx_exp.size() != 0 || tx_busy) && n < budget) begin
            tick();
            n++;
        end
        check("tx_drained", {31'h0, (tx_exp.size() == 0 && !tx_busy)}, 32'h1);
    endtask

    // Register-read monitor: every cycle with io_rd high consumes one expectation.
    initial begin : rd_mon
        forever begin
            @(negedge clk);
            if (resetq && io_rd) begin
                if (rd_exp.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rd_unexpected: got %0h want no read", io_din);
                end else begin
                    check(rd_name.pop_front(), io_din, rd_exp.pop_front());
                end
            end
        end
    end

    // Line monitor: every level of a frame must hold for exactly 4 samples.
    initial begin : tx_mon
        logic       prev, ok, aborted, have;
        logic [9:0] fr, got;
        logic [7:0] eb;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!resetq) begin
                prev = 1'b1;
            end else if (prev && !uart_tx) begin
                tx_busy = 1'b1;
                tx_starts.push_back(cyc);
                have = (tx_exp.size() != 0);
                fr = 10'h3ff;
                if (have) begin
                    eb = tx_exp.pop_front();
                    fr = {1'b1, eb, 1'b0};
                end else begin
                    total++;
                    bad++;
                    $display("FAIL tx_unexpected_frame: start at cycle %0d, want none", cyc);
                end
                ok = 1'b1;
                aborted = 1'b0;
                got = '0;
                for (int i = 0; i < 40; i++) begin
                    if (i > 0) @(negedge clk);
                    if (!resetq) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (uart_tx !== fr[i/4]) ok = 1'b0;
                    if (i % 4 == 2) got[i/4] = uart_tx;
                end
                if (have && !aborted) check("tx_frame", {21'h0, ok, got}, {21'h0, 1'b1, fr});
                prev = aborted ? 1'b1 : uart_tx;
                tx_busy = 1'b0;
            end else begin
                prev = uart_tx;
            end
        end
    end

    initial begin
        int w0, w;
        resetq  = 1'b1;
        io_rd   = 1'b0;
        io_wr   = 1'b0;
        io_addr = 16'h0;
        io_dout = 32'h0;
        uart_rx = 1'b1;
        #1 resetq = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_uart_tx", {31'h0, uart_tx}, 32'h1);
        resetq = 1'b1;
        tick();
        rd(A_STAT, 32'h9, "reset_status");
        rd(16'h3000, 32'h0, "unmapped_read");
        rd(A_DATA, 32'h0, "reset_data");

        // single 0x55 frame: start latency and idle at frame end
        tx_starts.delete();
        wr(8'h55, 1'b1, w0);
        wait_until(w0 + 40);
        rd(A_STAT, 32'h1, "stat_in_stop");
        wait_until(w0 + 42);
        rd(A_STAT, 32'h9, "stat_after_frame");
        check("start_latency", (tx_starts.size() == 1) ? tx_starts[0] - w0 : -1, 32'd2);

        // burst of six: last one overflows, five frames back to back
        tx_starts.delete();
        for (int i = 1; i <= 6; i++) begin
            wr(8'(i), (i <= 5), w);
            if (i == 1) w0 = w;
            if (i < 6) tick();
        end
        rd(A_STAT, 32'h20, "ovf_set");
        rd(A_STAT, 32'h0, "ovf_cleared");
        wait_tx_done(400);
        check("burst_frames", tx_starts.size(), 32'd5);
        if (tx_starts.size() == 5) begin
            check("burst_start_latency", tx_starts[0] - w0, 32'd2);
            for (int k = 1; k < 5; k++) check("burst_no_gap", tx_starts[k] - tx_starts[k-1], 32'd40);
        end
        rd(A_STAT, 32'h9, "idle_after_burst");

        // receive path
        rx_send(8'hA3, 1'b1);
        rd(A_STAT, 32'hB, "rx_valid_set");
        rd(A_DATA, 32'hA3, "rx_data_a3");
        rd(A_STAT, 32'h9, "rx_valid_cleared");
        rx_send(8'h11, 1'b1);
        rx_send(8'h22, 1'b1);
        rd(A_STAT, 32'hF, "rx_overrun");
        rd(A_DATA, 32'h11, "rx_keep_old");
        rd(A_STAT, 32'h9, "ovr_cleared");
        rx_send(8'h5A, 1'b0);
        rd(A_STAT, 32'h19, "rx_ferr");
        rd(A_DATA, 32'h11, "ferr_byte_discarded");
        rd(A_STAT, 32'h9, "ferr_cleared");

        // reset in the middle of a frame while the FIFO holds more bytes
        wr(8'h3C, 1'b1, w0);
        tick();
        wr(8'h3D, 1'b0, w);
        tick();
        wr(8'h3E, 1'b0, w);
        wait_until(w0 + 11);
        check("line_before_reset", {31'h0, uart_tx}, 32'h0);
        #3 resetq = 1'b0;
        #1;
        check("reset_mid_tx_line", {31'h0, uart_tx}, 32'h1);
        repeat (2) @(posedge clk);
        #1 resetq = 1'b1;
        tick();
        rd(A_STAT, 32'h9, "status_after_reset");
        repeat (60) tick();
        check("tx_queue_empty", tx_exp.size(), 32'd0);
        check("rd_queue_empty", rd_exp.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/j1_io_uart.md
Name: j1_io_uart

Overview:
- Memory-mapped I/O peripheral directly downstream of the j1 core's I/O bus.
- Decodes io_rd/io_wr against the CPU address (st0[15:0]), accepts CPU write data (st1), and returns io_din combinationally in the same cycle as the read instruction.
- Provides a UART transmitter with a small TX FIFO, a single-byte RX holding register, and a status register with sticky error bits.

Parameters:
- WIDTH, 32, CPU data width; must match the core.
- CLKDIV, 868, clock cycles per UART bit (100 MHz / 115200); minimum 4.
- TXDEPTH, 4, TX FIFO entries; power of two, minimum 2.
- ADDR_DATA, 16'h1000, UART data register address.
- ADDR_STAT, 16'h2000, UART status register address.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- resetq  in  1  reset, asynchronous, active-low.
- io_rd  in  1  CPU I/O read strobe; side effects take place at the clock edge.
- io_wr  in  1  CPU I/O write strobe.
- io_addr  in  16  CPU I/O address.
- io_dout  in  WIDTH  CPU write data; only bits [7:0] are used.
- io_din  out  WIDTH  read data; combinational function of io_addr and current state.
- uart_tx  out  1  serial output; idles at 1.
- uart_rx  in  1  serial input; asynchronous to clk.

Behaviour:
- Reset (resetq low):
  - All state is cleared asynchronously.
  - uart_tx=1, TX FIFO empty, TX FSM IDLE, RX FSM IDLE, rx_valid=0, all sticky bits 0.
- Read mux:
  - ADDR_DATA returns {0, rx_byte[7:0]}, valid or not.
  - ADDR_STAT returns {0, bit5 tx_ovf, bit4 rx_ferr, bit3 tx_idle, bit2 rx_ovr, bit1 rx_valid, bit0 tx_ready}.
  - Any other address returns 0.
  - io_din is driven whether or not io_rd is asserted.
- Read side effects:
  - io_rd at ADDR_DATA with rx_valid=1 clears rx_valid at the edge.
  - io_rd at ADDR_STAT clears rx_ovr, rx_ferr and tx_ovf at the edge. The value returned is the pre-clear value.
- Write side effects:
  - io_wr at ADDR_DATA pushes io_dout[7:0] into the TX FIFO.
  - If the FIFO is full, the byte is dropped and tx_ovf is set. There is no stall.
  - Writes to other addresses are ignored.
- io_rd and io_wr asserted together: each is processed independently.
- tx_ready = FIFO not full. tx_idle = FIFO empty and TX FSM in IDLE.
- TX FSM (IDLE, START, DATA, STOP):
  - IDLE with FIFO non-empty: pop one byte into the shifter and go to START. uart_tx=0 on the next cycle, so the start bit begins 2 cycles after the write edge.
  - Every bit lasts exactly CLKDIV cycles.
  - DATA sends 8 bits, LSB first.
  - STOP drives 1 for CLKDIV cycles. At its end, go to START directly if the FIFO is non-empty (no idle gap), else go to IDLE.
  - uart_tx is a flop output.
- RX:
  - 2-flop synchronizer on uart_rx.
  - IDLE detects a synced falling edge.
  - Sample at CLKDIV/2 to confirm the start bit. If the line is 1 there, abort to IDLE with no flags set.
  - Sample 8 data bits at CLKDIV intervals, LSB first, then the stop bit.
  - Stop=0: set rx_ferr, discard the byte, go to IDLE.
  - Stop=1 and rx_valid=0: load rx_byte and set rx_valid.
  - Stop=1 and rx_valid=1: set rx_ovr, discard the new byte, keep the old one.
  - Completion in the same cycle as a data-read pop: load the new byte, rx_valid stays 1, no overrun.
  - After the stop-bit sample, return to IDLE immediately, ready for the next start edge.
- Width rules:
  - The FIFO pointers are log2(TXDEPTH)+1 bits; full/empty are decided by the wrap bit.
  - The bit counter is 3 bits. The baud counter is sized by $clog2(CLKDIV).
- Push and pop in the same cycle on a full FIFO: the pop frees a slot, so the push is accepted and tx_ovf is not set.

Decomposition:
- Package j1_io_pkg holds:
  - default address constants;
  - status bit index constants (ST_TX_READY..ST_TX_OVF);
  - TX/RX FSM state encodings.
- One sub-module: j1_io_fifo, a synchronous FIFO parameterized by width and depth, with push, pop, full, empty and dout.
- The UART TX/RX logic stays in j1_io_uart.

Test Plan:
- All scenarios use CLKDIV=4 and TXDEPTH=4.
- Reset -> uart_tx=1; status read returns 32'h9 (tx_ready, tx_idle); a read of 16'h3000 returns 0.
- io_wr ADDR_DATA 0x55 -> start bit 2 cycles after the write edge; line sequence 0,1,0,1,0,1,0,1,0,1, each level held 4 cycles; then IDLE with tx_idle=1 40 cycles after the start bit begins.
- Six writes 0x01..0x06, spaced 2 cycles apart, while idle:
  - 5 bytes are accepted (1 in the shifter, 4 in the FIFO) and 0x06 is dropped.
  - Status bit5=1; bit5 clears after the status read.
  - 5 frames are sent back to back with no gap (200 cycles).
- Drive an RX frame of 0xA3 -> rx_valid=1; data read returns 0xA3; the next status read has bit1=0.
- Two RX frames 0x11 then 0x22 with no read between them -> status bit2=1; data reads 0x11; a second status read shows bit2=0.
- RX frame with stop bit=0 -> bit4=1 and rx_valid=0.
- resetq asserted mid-TX-frame -> uart_tx=1 immediately and FIFO empty; after release, status reads 32'h9.
